// File: rtl/exe_maint_pkg.sv
// exe_maint_pkg: op encodings, FSM states and watchdog constants shared by the
// maintenance arbiter and its optional watchdog.
package exe_maint_pkg;

    typedef enum logic [2:0] {
        OP_NONE     = 3'd0,
        OP_TLBCHECK = 3'd1,
        OP_TLBFLUSH = 3'd2,
        OP_WBINVD   = 3'd3,
        OP_INVDDATA = 3'd4,
        OP_INVDCODE = 3'd5
    } maint_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } maint_state_e;

    // Request vectors are ordered bit 0 = tlbcheck ... bit 4 = invdcode.
    localparam int                NUM_REQ  = 5;
    localparam int                WDOG_W   = 16;
    localparam logic [WDOG_W-1:0] WDOG_MAX = 16'hFFFF;

    function automatic maint_op_e req_priority_op(input logic [NUM_REQ-1:0] reqs);
        if (reqs[0])      return OP_TLBCHECK;
        else if (reqs[1]) return OP_TLBFLUSH;
        else if (reqs[2]) return OP_WBINVD;
        else if (reqs[3]) return OP_INVDDATA;
        else if (reqs[4]) return OP_INVDCODE;
        else              return OP_NONE;
    endfunction

    function automatic logic [NUM_REQ-1:0] op_done_vec(input maint_op_e op);
        logic [NUM_REQ-1:0] v;
        v = '0;
        case (op)
            OP_TLBCHECK: v[0] = 1'b1;
            OP_TLBFLUSH: v[1] = 1'b1;
            OP_WBINVD:   v[2] = 1'b1;
            OP_INVDDATA: v[3] = 1'b1;
            OP_INVDCODE: v[4] = 1'b1;
            default:     v    = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/exe_maint_watchdog.sv
// exe_maint_watchdog: per-state cycle counter that flags a stuck downstream
// handshake once the count reaches WDOG_MAX.
module exe_maint_watchdog
    import exe_maint_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expired
);

    logic [WDOG_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_run && (r_count == WDOG_MAX);

endmodule

// File: rtl/exe_maint_arbiter.sv
// exe_maint_arbiter: fixed-priority arbiter funnelling execute-stage TLB/cache
// maintenance requests onto one downstream port. Watchdog: EXE_MAINT_TIMEOUT_EN.
module exe_maint_arbiter
    import exe_maint_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exe_reset,
    input  logic        req_tlbcheck,
    input  logic        req_tlbflush,
    input  logic        req_wbinvd,
    input  logic        req_invddata,
    input  logic        req_invdcode,
    input  logic [31:0] tlbcheck_address,
    input  logic        tlbcheck_rw,
    input  logic [31:0] tlbflush_address,
    output logic        done_tlbcheck,
    output logic        done_tlbflush,
    output logic        done_wbinvd,
    output logic        done_invddata,
    output logic        done_invdcode,
    output logic        tlbcheck_page_fault,
    output logic        maint_valid,
    output logic [2:0]  maint_op,
    output logic [31:0] maint_address,
    output logic        maint_rw,
    input  logic        maint_accept,
    input  logic        maint_done,
    input  logic        maint_page_fault,
    output logic        maint_timeout
);

    maint_state_e       r_state;
    maint_state_e       w_state_next;
    maint_op_e          r_op;
    maint_op_e          w_op_next;
    maint_op_e          w_grant_op;
    logic [31:0]        r_address;
    logic [31:0]        w_address_next;
    logic [31:0]        w_grant_address;
    logic               r_rw;
    logic               w_rw_next;
    logic               w_grant_rw;
    logic [NUM_REQ-1:0] w_req_vec;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] w_done_next;
    logic               r_page_fault;
    logic               w_page_fault_next;
    logic               w_wdog_expired;

    assign w_req_vec  = {req_invdcode, req_invddata, req_wbinvd, req_tlbflush, req_tlbcheck};
    assign w_grant_op = req_priority_op(w_req_vec);

    // Only the TLB ops carry operands; everything else goes out as zero.
    always_comb begin
        w_grant_address = '0;
        w_grant_rw      = 1'b0;
        case (w_grant_op)
            OP_TLBCHECK: begin
                w_grant_address = tlbcheck_address;
                w_grant_rw      = tlbcheck_rw;
            end
            OP_TLBFLUSH: w_grant_address = tlbflush_address;
            default: ;
        endcase
    end

`ifdef EXE_MAINT_TIMEOUT_EN
    logic w_wdog_run;
    logic w_wdog_clear;
    logic r_timeout;

    assign w_wdog_run   = (r_state == ST_ISSUE) || (r_state == ST_WAIT) || (r_state == ST_DRAIN);
    assign w_wdog_clear = (w_state_next != r_state);

    exe_maint_watchdog u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_run     (w_wdog_run),
        .i_clear   (w_wdog_clear),
        .o_expired (w_wdog_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_wdog_expired;
        end
    end

    assign maint_timeout = r_timeout;
`else
    assign w_wdog_expired = 1'b0;
    assign maint_timeout  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_NONE;
            r_address    <= '0;
            r_rw         <= 1'b0;
            r_done       <= '0;
            r_page_fault <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_op         <= w_op_next;
            r_address    <= w_address_next;
            r_rw         <= w_rw_next;
            r_done       <= w_done_next;
            r_page_fault <= w_page_fault_next;
        end
    end

    // A flush after downstream has accepted must still wait for its maint_done.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!exe_reset && (w_grant_op != OP_NONE)) w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (maint_accept)   w_state_next = exe_reset ? ST_DRAIN : ST_WAIT;
                else if (exe_reset) w_state_next = ST_IDLE;
            end
            ST_WAIT: begin
                if (maint_done)     w_state_next = exe_reset ? ST_IDLE : ST_DONE;
                else if (exe_reset) w_state_next = ST_DRAIN;
            end
            ST_DONE: w_state_next = ST_IDLE;
            ST_DRAIN: begin
                if (maint_done) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_wdog_expired) w_state_next = ST_IDLE;
    end

    always_comb begin
        w_op_next         = r_op;
        w_address_next    = r_address;
        w_rw_next         = r_rw;
        w_done_next       = '0;
        w_page_fault_next = 1'b0;
        if ((r_state == ST_IDLE) && (w_state_next == ST_ISSUE)) begin
            w_op_next      = w_grant_op;
            w_address_next = w_grant_address;
            w_rw_next      = w_grant_rw;
        end else if (w_state_next == ST_IDLE) begin
            w_op_next      = OP_NONE;
            w_address_next = '0;
            w_rw_next      = 1'b0;
        end
        if (w_wdog_expired) begin
            if ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) w_done_next = op_done_vec(r_op);
        end else if ((r_state == ST_WAIT) && (w_state_next == ST_DONE)) begin
            w_done_next       = op_done_vec(r_op);
            w_page_fault_next = maint_page_fault && (r_op == OP_TLBCHECK);
        end
    end

    assign maint_valid         = (r_state == ST_ISSUE);
    assign maint_op            = r_op;
    assign maint_address       = r_address;
    assign maint_rw            = r_rw;
    assign tlbcheck_page_fault = r_page_fault;
    assign {done_invdcode, done_invddata, done_wbinvd, done_tlbflush, done_tlbcheck} = r_done;

endmodule

// File: tb/tb_exe_maint_arbiter.sv
// tb_exe_maint_arbiter: directed cases plus randomized traffic; every cycle the
// DUT outputs are compared with a transaction-level model of the arbiter.
module tb_exe_maint_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, exe_reset;
    logic        req_tlbcheck, req_tlbflush, req_wbinvd, req_invddata, req_invdcode;
    logic [31:0] tlbcheck_address, tlbflush_address;
    logic        tlbcheck_rw;
    logic        done_tlbcheck, done_tlbflush, done_wbinvd, done_invddata, done_invdcode;
    logic        tlbcheck_page_fault;
    logic        maint_valid;
    logic [2:0]  maint_op;
    logic [31:0] maint_address;
    logic        maint_rw;
    logic        maint_accept, maint_done, maint_page_fault;
    logic        maint_timeout;
    logic [4:0]  dut_done;

    exe_maint_arbiter dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .exe_reset           (exe_reset),
        .req_tlbcheck        (req_tlbcheck),
        .req_tlbflush        (req_tlbflush),
        .req_wbinvd          (req_wbinvd),
        .req_invddata        (req_invddata),
        .req_invdcode        (req_invdcode),
        .tlbcheck_address    (tlbcheck_address),
        .tlbcheck_rw         (tlbcheck_rw),
        .tlbflush_address    (tlbflush_address),
        .done_tlbcheck       (done_tlbcheck),
        .done_tlbflush       (done_tlbflush),
        .done_wbinvd         (done_wbinvd),
        .done_invddata       (done_invddata),
        .done_invdcode       (done_invdcode),
        .tlbcheck_page_fault (tlbcheck_page_fault),
        .maint_valid         (maint_valid),
        .maint_op            (maint_op),
        .maint_address       (maint_address),
        .maint_rw            (maint_rw),
        .maint_accept        (maint_accept),
        .maint_done          (maint_done),
        .maint_page_fault    (maint_page_fault),
        .maint_timeout       (maint_timeout)
    );

    assign dut_done = {done_invdcode, done_invddata, done_wbinvd, done_tlbflush, done_tlbcheck};

`ifdef EXE_MAINT_TIMEOUT_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Transaction view: a granted request is owned until it completes, is flushed
    // or times out; after a completion one cooldown cycle blocks new grants.
    bit          m_owned, m_accepted, m_abandoned, m_cool;
    int          m_who, m_age;
    logic [31:0] m_addr;
    logic        m_rw;
    logic [4:0]  m_done;
    logic        m_pf, m_to;

    task automatic model_step();
        logic [4:0] reqs;
        bit was_owned, was_acc, was_ab, was_cool, wd_fire;
        reqs      = {req_invdcode, req_invddata, req_wbinvd, req_tlbflush, req_tlbcheck};
        was_owned = m_owned;
        was_acc   = m_accepted;
        was_ab    = m_abandoned;
        was_cool  = m_cool;
        m_done    = '0;
        m_pf      = 1'b0;
        m_to      = 1'b0;
        wd_fire   = WDOG_ON && m_owned && (m_age == 65535);
        if (!rst_n) begin
            m_owned = 0; m_accepted = 0; m_abandoned = 0; m_cool = 0; m_age = 0;
        end else if (wd_fire) begin
            m_to = 1'b1;
            if (!m_abandoned) m_done[m_who] = 1'b1;
            m_owned = 0; m_accepted = 0; m_abandoned = 0;
        end else if (m_cool) begin
            m_cool = 0;
        end else if (!m_owned) begin
            if (!exe_reset && (reqs != 0)) begin
                for (int i = 4; i >= 0; i--) if (reqs[i]) m_who = i;
                m_owned = 1; m_accepted = 0; m_abandoned = 0;
                m_addr  = (m_who == 0) ? tlbcheck_address : (m_who == 1) ? tlbflush_address : 32'h0;
                m_rw    = (m_who == 0) ? tlbcheck_rw : 1'b0;
            end
        end else if (m_abandoned) begin
            if (maint_done) begin m_owned = 0; m_accepted = 0; m_abandoned = 0; end
        end else if (!m_accepted) begin
            if (maint_accept) begin m_accepted = 1; m_abandoned = exe_reset; end
            else if (exe_reset) m_owned = 0;
        end else begin
            if (maint_done) begin
                m_owned = 0; m_accepted = 0;
                if (!exe_reset) begin
                    m_done[m_who] = 1'b1;
                    m_pf          = (m_who == 0) && maint_page_fault;
                    m_cool        = 1;
                end
            end else if (exe_reset) begin
                m_abandoned = 1;
            end
        end
        if (rst_n) begin
            if ((was_owned != m_owned) || (was_acc != m_accepted) ||
                (was_ab != m_abandoned) || (was_cool != m_cool)) m_age = 0;
            else if (m_owned) m_age++;
        end
    endtask

    always @(posedge clk) begin
        logic busy;
        model_step();
        cyc++;
        #1;
        busy = m_owned || m_cool;
        chk("valid", maint_valid, m_owned && !m_accepted);
        chk("op", maint_op, busy ? m_who + 1 : 0);
        chk("address", maint_address, busy ? m_addr : 32'h0);
        chk("rw", maint_rw, busy ? m_rw : 1'b0);
        chk("done", dut_done, m_done);
        chk("done_excl", $onehot0(dut_done), 1);
        chk("page_fault", tlbcheck_page_fault, m_pf);
        chk("timeout", maint_timeout, m_to);
    end

    initial begin
        int order[$];
        int both, ndone, seen;
        rst_n = 0; exe_reset = 0;
        req_tlbcheck = 0; req_tlbflush = 0; req_wbinvd = 0; req_invddata = 0; req_invdcode = 0;
        tlbcheck_address = 0; tlbcheck_rw = 0; tlbflush_address = 0;
        maint_accept = 0; maint_done = 0; maint_page_fault = 0;
        repeat (3) @(negedge clk);
        chk("reset_valid", maint_valid, 0);
        chk("reset_op", maint_op, 0);
        chk("reset_done", dut_done, 0);
        chk("reset_timeout", maint_timeout, 0);
        rst_n = 1;

        // best-case tlbcheck: done three cycles after the request
        @(negedge clk);
        req_tlbcheck = 1; tlbcheck_address = 32'h0040_1000; tlbcheck_rw = 1;
        maint_accept = 1; maint_done = 1;
        @(negedge clk);
        chk("d1_valid", maint_valid, 1);
        chk("d1_op", maint_op, 1);
        chk("d1_addr", maint_address, 32'h0040_1000);
        chk("d1_rw", maint_rw, 1);
        @(negedge clk);
        chk("d1_done_early", done_tlbcheck, 0);
        @(negedge clk);
        chk("d1_done", done_tlbcheck, 1);
        req_tlbcheck = 0;
        @(negedge clk);
        chk("d1_done_once", done_tlbcheck, 0);
        @(negedge clk);
        chk("d1_no_regrant", maint_valid, 0);
        maint_accept = 0; maint_done = 0;

        // tlbflush and invdcode together: flush first, never overlapping
        @(negedge clk);
        tlbflush_address = 32'hABCD_E000; req_tlbflush = 1; req_invdcode = 1;
        maint_accept = 1; maint_done = 1; both = 0;
        for (int k = 0; k < 20 && (req_tlbflush || req_invdcode); k++) begin
            @(negedge clk);
            if (done_tlbflush && done_invdcode) both++;
            if (done_tlbflush) begin order.push_back(2); req_tlbflush = 0; end
            if (done_invdcode) begin order.push_back(5); req_invdcode = 0; end
        end
        chk("d2_count", order.size(), 2);
        if (order.size() == 2) begin
            chk("d2_first", order[0], 2);
            chk("d2_second", order[1], 5);
        end
        chk("d2_overlap", both, 0);
        maint_accept = 0; maint_done = 0;

        // page fault reported with done_tlbcheck only
        @(negedge clk);
        req_tlbcheck = 1; tlbcheck_address = 32'h1234_5000; tlbcheck_rw = 0;
        maint_accept = 1; maint_done = 1; maint_page_fault = 1;
        repeat (3) @(negedge clk);
        chk("d3_done", done_tlbcheck, 1);
        chk("d3_pf", tlbcheck_page_fault, 1);
        req_tlbcheck = 0; maint_page_fault = 0;
        @(negedge clk);
        chk("d3_pf_clear", tlbcheck_page_fault, 0);
        maint_accept = 0; maint_done = 0;

        // flush while waiting: drain, no done, then a fresh invddata
        @(negedge clk);
        req_tlbflush = 1; tlbflush_address = 32'h0000_8000; maint_accept = 1;
        @(negedge clk);
        chk("d4_valid", maint_valid, 1);
        chk("d4_op", maint_op, 2);
        @(negedge clk);
        chk("d4_wait", maint_valid, 0);
        exe_reset = 1; maint_accept = 0; ndone = 0;
        @(negedge clk);
        exe_reset = 0; req_tlbflush = 0;
        if (dut_done != 0) ndone++;
        repeat (4) begin
            @(negedge clk);
            if (dut_done != 0) ndone++;
        end
        chk("d4_draining_op", maint_op, 2);
        maint_done = 1;
        @(negedge clk);
        if (dut_done != 0) ndone++;
        chk("d4_idle_op", maint_op, 0);
        chk("d4_no_done", ndone, 0);
        req_invddata = 1; maint_accept = 1;
        repeat (3) @(negedge clk);
        chk("d4_invd_done", done_invddata, 1);
        req_invddata = 0;
        @(negedge clk);
        maint_accept = 0; maint_done = 0;

        // reset during ISSUE
        @(negedge clk);
        req_wbinvd = 1;
        @(negedge clk);
        chk("d5_valid", maint_valid, 1);
        chk("d5_op", maint_op, 3);
        chk("d5_addr", maint_address, 0);
        rst_n = 0;
        @(negedge clk);
        chk("d5_rst_valid", maint_valid, 0);
        chk("d5_rst_op", maint_op, 0);
        rst_n = 1; req_wbinvd = 0;

        // randomized traffic; requesters hold their line until their done pulse
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (done_tlbcheck) req_tlbcheck = 0;
            else if (!req_tlbcheck && $urandom_range(99) < 20) begin
                req_tlbcheck = 1; tlbcheck_address = $urandom; tlbcheck_rw = 1'($urandom_range(1));
            end
            if (done_tlbflush) req_tlbflush = 0;
            else if (!req_tlbflush && $urandom_range(99) < 20) begin
                req_tlbflush = 1; tlbflush_address = $urandom;
            end
            if (done_wbinvd) req_wbinvd = 0;
            else if (!req_wbinvd && $urandom_range(99) < 15) req_wbinvd = 1;
            if (done_invddata) req_invddata = 0;
            else if (!req_invddata && $urandom_range(99) < 15) req_invddata = 1;
            if (done_invdcode) req_invdcode = 0;
            else if (!req_invdcode && $urandom_range(99) < 15) req_invdcode = 1;
            exe_reset        = ($urandom_range(99) < 4);
            rst_n            = ($urandom_range(199) != 0);
            maint_accept     = ($urandom_range(99) < 50);
            maint_done       = ($urandom_range(99) < 35);
            maint_page_fault = 1'($urandom_range(1));
        end

        // stuck downstream: watchdog expiry, or a WAIT that never ends
        @(negedge clk);
        rst_n = 0; exe_reset = 0;
        req_tlbcheck = 0; req_tlbflush = 0; req_wbinvd = 0; req_invddata = 0; req_invdcode = 0;
        maint_accept = 0; maint_done = 0; maint_page_fault = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        req_tlbcheck = 1; tlbcheck_address = 32'hCAFE_0000; tlbcheck_rw = 0; maint_accept = 1;
`ifdef EXE_MAINT_TIMEOUT_EN
        seen = -1;
        for (int k = 1; k <= 66000 && seen < 0; k++) begin
            @(negedge clk);
            if (maint_timeout) begin
                seen = k;
                chk("wd_done", done_tlbcheck, 1);
                chk("wd_pf", tlbcheck_page_fault, 0);
                req_tlbcheck = 0;
            end
        end
        chk("wd_cycle", seen, 65538);
`else
        ndone = 0;
        repeat (66000) begin
            @(negedge clk);
            if (dut_done != 0 || maint_timeout) ndone++;
        end
        chk("wd_off_quiet", ndone, 0);
        maint_done = 1;
        @(negedge clk);
        chk("wd_off_done", done_tlbcheck, 1);
        req_tlbcheck = 0; maint_done = 0;
`endif
        maint_accept = 0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
